// File: rtl/write_pointer_handler_pkg.sv
// rtl/write_pointer_handler_pkg.sv - pointer width and Gray-code helpers shared by the FIFO pointer handlers
package write_pointer_handler_pkg;

  localparam int GRAY_FN_W = 32;

  function automatic int ptr_w(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic logic [GRAY_FN_W-1:0] bin2gray(input logic [GRAY_FN_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/write_pointer_handler_if.sv
// rtl/write_pointer_handler_if.sv - write-side request/flag bundle of the async FIFO
interface write_pointer_handler_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                  wpush;
  logic [ADDR_WIDTH:0]   wq2_rptr;
  logic                  wclr_ovf;
  logic                  wen;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [ADDR_WIDTH:0]   wptr;
  logic                  wfull;
  logic                  walmost_full;
  logic [ADDR_WIDTH:0]   wlevel;
  logic                  woverflow;

  modport master (
    output wpush, wq2_rptr, wclr_ovf,
    input  wen, waddr, wptr, wfull, walmost_full, wlevel, woverflow
  );

  modport slave (
    input  wpush, wq2_rptr, wclr_ovf,
    output wen, waddr, wptr, wfull, walmost_full, wlevel, woverflow
  );
endinterface

// File: rtl/write_pointer_handler_gray_to_bin.sv
// rtl/write_pointer_handler_gray_to_bin.sv - Gray to binary converter for the synced read pointer
module gray_to_bin #(
  parameter int W = 5
) (
  input  logic [W-1:0] i_gray,
  output logic [W-1:0] o_bin
);

  // Each binary bit is the XOR of its Gray bit and every Gray bit above it.
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign o_bin[i] = ^i_gray[W-1:i];
  end

endmodule

// File: rtl/write_pointer_handler.sv
// rtl/write_pointer_handler.sv - write-domain pointer, full/level flags and sticky overflow of the async FIFO
module write_pointer_handler
  import write_pointer_handler_pkg::*;
#(
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic                      wclk,
  input  logic                      wrst_n,
  write_pointer_handler_if.slave    bus
);

  localparam int            PW        = ptr_w(ADDR_WIDTH);
  localparam logic [PW-1:0] AFULL_LIM = PW'(AFULL_THRESH);

  logic [PW-1:0] r_wbin;
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_wlevel;
  logic          r_wfull;
  logic          r_walmost_full;
  logic          r_woverflow;

  logic [PW-1:0] w_rbin;
  logic [PW-1:0] w_n_wbin;
  logic [PW-1:0] w_n_wgray;
  logic [PW-1:0] w_n_level;
  logic [PW-1:0] w_full_gray;
  logic          w_accept;
  logic          w_n_wfull;
  logic          w_n_woverflow;

  gray_to_bin #(.W(PW)) u_gray_to_bin (
    .i_gray (bus.wq2_rptr),
    .o_bin  (w_rbin)
  );

  // Full when the next write pointer sits exactly one lap ahead of the synced read pointer.
  always_comb begin
    w_accept      = bus.wpush & ~r_wfull;
    w_n_wbin      = r_wbin + {{(PW-1){1'b0}}, w_accept};
    w_n_wgray     = PW'(bin2gray(GRAY_FN_W'(w_n_wbin)));
    w_full_gray   = {~bus.wq2_rptr[PW-1:PW-2], bus.wq2_rptr[PW-3:0]};
    w_n_wfull     = (w_n_wgray == w_full_gray);
    w_n_level     = w_n_wbin - w_rbin;
    w_n_woverflow = r_woverflow;
    if (bus.wpush && r_wfull) begin
      w_n_woverflow = 1'b1;
    end else if (bus.wclr_ovf) begin
      w_n_woverflow = 1'b0;
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_wbin         <= '0;
      r_wptr         <= '0;
      r_wlevel       <= '0;
      r_wfull        <= 1'b0;
      r_walmost_full <= 1'b0;
      r_woverflow    <= 1'b0;
    end else begin
      r_wbin         <= w_n_wbin;
      r_wptr         <= w_n_wgray;
      r_wlevel       <= w_n_level;
      r_wfull        <= w_n_wfull;
      r_walmost_full <= (w_n_level >= AFULL_LIM);
      r_woverflow    <= w_n_woverflow;
    end
  end

  assign bus.wen          = w_accept;
  assign bus.waddr        = r_wbin[ADDR_WIDTH-1:0];
  assign bus.wptr         = r_wptr;
  assign bus.wfull        = r_wfull;
  assign bus.walmost_full = r_walmost_full;
  assign bus.wlevel       = r_wlevel;
  assign bus.woverflow    = r_woverflow;

endmodule

// File: tb/tb_write_pointer_handler.sv
// tb/tb_write_pointer_handler.sv - scoreboard bench for write_pointer_handler
module tb_write_pointer_handler;

  localparam int AW = 4;
  localparam int PW = AW + 1;
  localparam int TH = 12;

  logic wclk   = 1'b0;
  logic wrst_n = 1'b0;

  always #5 wclk = ~wclk;

  write_pointer_handler_if #(.ADDR_WIDTH(AW)) bus ();

  write_pointer_handler #(.ADDR_WIDTH(AW), .AFULL_THRESH(TH)) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .bus    (bus)
  );

  typedef struct {
    logic [PW-1:0] wptr;
    logic          wfull;
    logic          wafull;
    logic [PW-1:0] wlevel;
    logic          wovf;
    logic [AW-1:0] waddr;
  } exp_t;

  exp_t          sb[$];
  int            n_pass  = 0;
  int            n_total = 0;
  logic [PW-1:0] m_bin;
  logic          m_full;
  logic          m_ovf;
  logic [PW-1:0] last_wptr;
  bit            mon_en = 1'b0;

  function automatic logic [PW-1:0] tb_g2b(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [PW-1:0] tb_b2g(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_bin  = '0;
    m_full = 1'b0;
    m_ovf  = 1'b0;
    sb.delete();
  endtask

  // One wclk cycle: drive inputs, predict, clock, compare the popped expectation.
  task automatic cycle(input logic push, input logic [PW-1:0] rq, input logic clr);
    exp_t          e;
    logic [PW-1:0] lvl;
    logic          acc;
    bus.wpush    = push;
    bus.wq2_rptr = rq;
    bus.wclr_ovf = clr;
    #1;
    acc = push && !m_full;
    check("wen", 32'(bus.wen), 32'(acc));
    m_ovf  = (push && m_full) ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_bin  = m_bin + PW'(acc);
    lvl    = m_bin - tb_g2b(rq);
    m_full = (lvl == PW'(16));
    e = '{tb_b2g(m_bin), m_full, (lvl >= PW'(TH)), lvl, m_ovf, m_bin[AW-1:0]};
    sb.push_back(e);
    last_wptr = bus.wptr;
    @(posedge wclk);
    #1;
    e = sb.pop_front();
    check("wptr",   32'(bus.wptr),         32'(e.wptr));
    check("wfull",  32'(bus.wfull),        32'(e.wfull));
    check("wafull", 32'(bus.walmost_full), 32'(e.wafull));
    check("wlevel", 32'(bus.wlevel),       32'(e.wlevel));
    check("wovf",   32'(bus.woverflow),    32'(e.wovf));
    check("waddr",  32'(bus.waddr),        32'(e.waddr));
    if (mon_en) check("wptr_1bit", 32'($countones(bus.wptr ^ last_wptr) <= 1), 32'(1));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_wptr"},   32'(bus.wptr),         32'(0));
    check({tag, "_wfull"},  32'(bus.wfull),        32'(0));
    check({tag, "_wafull"}, 32'(bus.walmost_full), 32'(0));
    check({tag, "_wlevel"}, 32'(bus.wlevel),       32'(0));
    check({tag, "_wovf"},   32'(bus.woverflow),    32'(0));
    check({tag, "_waddr"},  32'(bus.waddr),        32'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PW-1:0] h1, h2;
    logic [AW-1:0] prev_addr;
    logic          prev_msb;
    int            msb_toggles;
    bit            saw_wrap;
    bit            saw_full;

    bus.wpush    = 1'b1;
    bus.wq2_rptr = '0;
    bus.wclr_ovf = 1'b0;
    model_reset();
    repeat (3) @(posedge wclk);
    #1;
    check_zero("reset");
    wrst_n = 1'b1;

    cycle(1'b1, '0, 1'b0);
    check("first_waddr",  32'(bus.waddr),  32'(1));
    check("first_wptr",   32'(bus.wptr),   32'(5'b00001));
    check("first_wlevel", 32'(bus.wlevel), 32'(1));

    for (int k = 2; k <= 16; k++) begin
      cycle(1'b1, '0, 1'b0);
      check("afull_by_count", 32'(bus.walmost_full), 32'(k >= TH));
    end
    check("full_wfull",  32'(bus.wfull),  32'(1));
    check("full_wptr",   32'(bus.wptr),   32'(5'b11000));
    check("full_wlevel", 32'(bus.wlevel), 32'(16));

    cycle(1'b1, '0, 1'b0);
    check("ovf_wptr_held", 32'(bus.wptr),      32'(5'b11000));
    check("ovf_set",       32'(bus.woverflow), 32'(1));
    cycle(1'b0, '0, 1'b1);
    check("ovf_cleared",   32'(bus.woverflow), 32'(0));
    cycle(1'b1, '0, 1'b1);
    check("ovf_set_wins",  32'(bus.woverflow), 32'(1));
    cycle(1'b0, '0, 1'b1);

    cycle(1'b0, 5'b00001, 1'b0);
    check("read_wfull",  32'(bus.wfull),  32'(0));
    check("read_wlevel", 32'(bus.wlevel), 32'(15));
    cycle(1'b1, 5'b00001, 1'b0);
    check("refill_wfull",  32'(bus.wfull),  32'(1));
    check("refill_wlevel", 32'(bus.wlevel), 32'(16));

    cycle(1'b0, tb_b2g(m_bin), 1'b0);
    check("drained_wlevel", 32'(bus.wlevel), 32'(0));

    h1 = tb_b2g(m_bin);
    h2 = h1;
    prev_addr   = bus.waddr;
    prev_msb    = bus.wptr[PW-1];
    msb_toggles = 0;
    saw_wrap    = 1'b0;
    saw_full    = 1'b0;
    mon_en      = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, h2, 1'b0);
      h2 = h1;
      h1 = tb_b2g(m_bin);
      if (prev_addr == 4'd15 && bus.waddr == 4'd0) saw_wrap = 1'b1;
      if (bus.wptr[PW-1] != prev_msb) msb_toggles++;
      if (bus.wfull) saw_full = 1'b1;
      prev_addr = bus.waddr;
      prev_msb  = bus.wptr[PW-1];
    end
    mon_en = 1'b0;
    check("track_wrap",        32'(saw_wrap),    32'(1));
    check("track_msb_toggles", 32'(msb_toggles), 32'(2));
    check("track_never_full",  32'(saw_full),    32'(0));

    model_reset();
    wrst_n = 1'b0;
    #1;
    wrst_n = 1'b1;
    for (int i = 0; i < 5; i++) cycle(1'b1, '0, 1'b0);
    bus.wpush = 1'b1;
    @(posedge wclk);
    #3;
    wrst_n = 1'b0;
    #1;
    check_zero("async_reset");
    model_reset();
    @(posedge wclk);
    #1;
    wrst_n = 1'b1;
    cycle(1'b1, '0, 1'b0);
    check("post_reset_waddr", 32'(bus.waddr), 32'(1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
